panel_cmdgen: RTL and testbench

- Front-panel command generator: the producer side of the phase generator's run / step_phase / step_inst inputs.
- Turns three raw, bouncing push-buttons into clean single-cycle command pulses: synchronised, debounced, rising-edge detected, arbitrated.
- Watches cstate / running / pc and issues the stop command itself when a hardware PC breakpoint is hit during free run.
- Sits between the board's button pins and phasegen, beside the debug LEDs.

---
 rtl/panel_cmdgen.sv | 136 +++++++++++++
 tb/tb_panel_cmdgen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/panel_cmdgen.sv
// Front-panel command generator: synchronises and debounces three push-buttons into
// single-cycle run/step commands and issues the breakpoint stop during free run.
module panel_cmdgen #(
  parameter int DB_WIDTH = 16,
  parameter int DB_COUNT = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step_phase,
  input  logic        btn_step_inst,
  input  logic [3:0]  cstate,
  input  logic        running,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  output logic        run,
  output logic        step_phase,
  output logic        step_inst,
  output logic        free_run,
  output logic        bp_hit
);

  // Button index doubles as priority: lower index wins.
  localparam int NB = 3;
  localparam int B_RUN = 0;
  localparam int B_INST = 1;
  localparam int B_PHASE = 2;
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);
  localparam logic [3:0] PH_IF = 4'b0001;

  logic [NB-1:0]       btn_raw;
  logic [NB-1:0]       sync_p0, sync_p1;
  logic [NB-1:0]       stable;
  logic [DB_WIDTH-1:0] cnt [NB];
  logic [NB-1:0]       rise;
  logic [NB-1:0]       pend, pend_n;
  logic                run_n, step_inst_n, step_phase_n;
  logic                free_run_n, bp_hit_n, armed, armed_n;
  logic                rearm, match;

  assign btn_raw = {btn_step_phase, btn_step_inst, btn_run};

  // Stage p0/p1: two-flop synchroniser, then per-button debounce counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      stable  <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]    <= '0;
          stable[i] <= sync_p1[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A rise is flagged on the same edge the stable level goes high, so the
  // pending bit lands together with the new level.
  always_comb begin
    rise = '0;
    for (int i = 0; i < NB; i++)
      rise[i] = sync_p1[i] & ~stable[i] & (cnt[i] == DB_LAST);
  end

  // The run output gate keeps a stop from following a run pulse back to back.
  always_comb begin
    rearm = (cstate != PH_IF) || (pc != bp_addr);
    match = bp_en && free_run && running && (cstate == PH_IF) &&
            (pc == bp_addr) && armed && !run;
  end

  always_comb begin
    pend_n       = pend;
    run_n        = 1'b0;
    step_inst_n  = 1'b0;
    step_phase_n = 1'b0;
    bp_hit_n     = bp_hit;
    armed_n      = armed;
    free_run_n   = free_run;
    if (match) begin
      run_n         = 1'b1;
      pend_n[B_RUN] = 1'b0;
      bp_hit_n      = 1'b1;
    end else if (pend[B_RUN]) begin
      run_n         = 1'b1;
      pend_n[B_RUN] = 1'b0;
      bp_hit_n      = 1'b0;
    end else if (pend[B_INST]) begin
      step_inst_n    = 1'b1;
      pend_n[B_INST] = 1'b0;
      bp_hit_n       = 1'b0;
    end else if (pend[B_PHASE]) begin
      step_phase_n    = 1'b1;
      pend_n[B_PHASE] = 1'b0;
      bp_hit_n        = 1'b0;
    end
    pend_n = pend_n | rise;
    // free_run follows the run pulse while it is on the wire, when phasegen sees it
    if (run) free_run_n = !running;
    else if (free_run && !running) free_run_n = 1'b0;
    if (match || (run && !running)) armed_n = 1'b0;
    else if (rearm) armed_n = 1'b1;
  end

  // Stage p2: registered command pulses and run/breakpoint status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend       <= '0;
      run        <= 1'b0;
      step_inst  <= 1'b0;
      step_phase <= 1'b0;
      free_run   <= 1'b0;
      bp_hit     <= 1'b0;
      armed      <= 1'b0;
    end else begin
      pend       <= pend_n;
      run        <= run_n;
      step_inst  <= step_inst_n;
      step_phase <= step_phase_n;
      free_run   <= free_run_n;
      bp_hit     <= bp_hit_n;
      armed      <= armed_n;
    end
  end

endmodule

// File: tb/tb_panel_cmdgen.sv
// Directed bench for panel_cmdgen with a short debounce window.
module tb_panel_cmdgen;

  logic        clock = 1'b0;
  logic        reset;
  logic        btn_run, btn_step_phase, btn_step_inst;
  logic [3:0]  cstate;
  logic        running;
  logic [31:0] pc, bp_addr;
  logic        bp_en;
  logic        run, step_phase, step_inst, free_run, bp_hit;
  logic [2:0]  cmd;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] C_NONE  = 3'b000;
  localparam logic [2:0] C_RUN   = 3'b100;
  localparam logic [2:0] C_INST  = 3'b010;
  localparam logic [2:0] C_PHASE = 3'b001;

  assign cmd = {run, step_inst, step_phase};

  panel_cmdgen #(.DB_WIDTH(4), .DB_COUNT(4)) dut (
    .clock(clock), .reset(reset),
    .btn_run(btn_run), .btn_step_phase(btn_step_phase), .btn_step_inst(btn_step_inst),
    .cstate(cstate), .running(running), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .run(run), .step_phase(step_phase), .step_inst(step_inst),
    .free_run(free_run), .bp_hit(bp_hit)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n edges; at edge 'at' the command vector must equal pat, otherwise idle
  task automatic win(input string tag, input int n, input int at, input logic [2:0] pat);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk(tag, {29'd0, cmd}, {29'd0, (e == at) ? pat : C_NONE});
    end
  endtask

  initial begin
    reset = 1'b0;
    btn_run = 0; btn_step_phase = 0; btn_step_inst = 0;
    cstate = 4'b0001; running = 0; pc = 32'h0; bp_addr = 32'h10; bp_en = 0;
    tick(); tick();
    chk("reset_cmd", {29'd0, cmd}, 32'd0);
    chk("reset_free_run", {31'd0, free_run}, 32'd0);
    chk("reset_bp_hit", {31'd0, bp_hit}, 32'd0);
    reset = 1'b1;
    tick();

    // clean step_inst press: pulse 7 edges later, nothing while held or on release
    btn_step_inst = 1;
    win("step_inst_press", 9, 7, C_INST);
    win("step_inst_hold", 10, 0, C_NONE);
    btn_step_inst = 0;
    win("step_inst_release", 12, 0, C_NONE);

    // bouncing run button, then held: final rise happens at k=8
    for (int k = 0; k < 10; k++) begin
      btn_run = ((k / 2) % 2 == 0);
      tick();
      chk("run_bounce", {29'd0, cmd}, 32'd0);
    end
    win("run_after_bounce", 7, 5, C_RUN);
    btn_run = 0;
    win("run_bounce_release", 12, 0, C_NONE);

    // simultaneous rises: run, step_inst, step_phase on consecutive cycles
    btn_run = 1; btn_step_inst = 1; btn_step_phase = 1;
    win("arb_wait", 6, 0, C_NONE);
    tick(); chk("arb_run", {29'd0, cmd}, {29'd0, C_RUN});
    tick(); chk("arb_inst", {29'd0, cmd}, {29'd0, C_INST});
    chk("arb_free_run_set", {31'd0, free_run}, 32'd1);
    tick(); chk("arb_phase", {29'd0, cmd}, {29'd0, C_PHASE});
    chk("arb_free_run_drop", {31'd0, free_run}, 32'd0);
    btn_run = 0; btn_step_inst = 0; btn_step_phase = 0;
    win("arb_idle", 12, 0, C_NONE);

    // breakpoint stop during free run
    bp_en = 1; bp_addr = 32'h10; pc = 32'h0; cstate = 4'b0001; running = 0;
    btn_run = 1;
    win("bp_start", 7, 7, C_RUN);
    tick();
    running = 1; cstate = 4'b0010; pc = 32'h0C;
    chk("bp_free_run_on", {31'd0, free_run}, 32'd1);
    tick();
    btn_run = 0;
    cstate = 4'b0001; pc = 32'h10;
    tick();
    chk("bp_stop_pulse", {29'd0, cmd}, {29'd0, C_RUN});
    chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    tick();
    chk("bp_single_stop", {29'd0, cmd}, 32'd0);
    chk("bp_free_run_off", {31'd0, free_run}, 32'd0);
    chk("bp_hit_sticky", {31'd0, bp_hit}, 32'd1);
    running = 0;
    win("bp_idle", 8, 0, C_NONE);
    chk("bp_hit_held", {31'd0, bp_hit}, 32'd1);

    // resume at the breakpoint address: no immediate re-hit
    btn_run = 1;
    win("resume_press", 6, 0, C_NONE);
    tick();
    chk("resume_pulse", {29'd0, cmd}, {29'd0, C_RUN});
    chk("resume_bp_hit_clr", {31'd0, bp_hit}, 32'd0);
    tick();
    running = 1;
    chk("resume_free_run", {31'd0, free_run}, 32'd1);
    btn_run = 0;
    win("resume_no_rehit", 6, 0, C_NONE);
    cstate = 4'b0010;
    tick();
    chk("resume_leave_if", {29'd0, cmd}, 32'd0);
    cstate = 4'b0001;
    tick();
    chk("resume_second_stop", {29'd0, cmd}, {29'd0, C_RUN});
    chk("resume_bp_hit_again", {31'd0, bp_hit}, 32'd1);
    tick();
    running = 0;
    win("resume_idle", 10, 0, C_NONE);

    // reset during free run with a press in mid-debounce
    btn_run = 1;
    win("rst_start", 7, 7, C_RUN);
    tick();
    running = 1;
    chk("rst_free_run_on", {31'd0, free_run}, 32'd1);
    btn_step_phase = 1;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_cmd", {29'd0, cmd}, 32'd0);
    chk("rst_free_run", {31'd0, free_run}, 32'd0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    btn_run = 0; btn_step_phase = 0; running = 0;
    tick(); tick();
    reset = 1'b1;
    win("rst_after_release", 15, 0, C_NONE);
    chk("rst_free_run_idle", {31'd0, free_run}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
